// File: rtl/cond_path_delay_gen.sv
// Clocked stand-in for a conditional sel=>zout specify path: per-condition
// rise/fall delays from a writable table, applied with inertial pulse rejection.
module cond_path_delay_gen #(
    parameter int DW        = 4,
    parameter int DEF_DELAY = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mode,
    input  logic          sel,
    output logic          zout,
    output logic          busy,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic          wr_cond,
    input  logic          wr_edge,
    input  logic [DW-1:0] wr_delay,
    output logic [7:0]    rej_cnt
);

    // Handshake: a table write happens on every rising edge where
    // wr_valid && wr_ready; wr_ready rises one edge after reset release
    // and then stays high, so a held request is taken on the next edge.

    typedef enum logic {IDLE, PEND} state_t;

    state_t        state;
    logic          tgt;
    logic [DW-1:0] cnt;
    logic [DW-1:0] tbl [4];
    logic [1:0]    det_idx;

    // Table index is {condition, edge}; edge is 0 for a rise (sel going to 1).
    assign det_idx = {mode, ~sel};
    assign busy    = (state == PEND);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tgt      <= 1'b0;
            cnt      <= '0;
            zout     <= 1'b0;
            wr_ready <= 1'b0;
            rej_cnt  <= 8'd0;
            for (int i = 0; i < 4; i++) begin
                tbl[i] <= DW'(DEF_DELAY);
            end
        end else begin
            wr_ready <= 1'b1;
            // Non-blocking update: a detect on this same edge still reads the old entry.
            if (wr_valid && wr_ready) begin
                tbl[{wr_cond, wr_edge}] <= wr_delay;
            end
            case (state)
                IDLE: begin
                    if (sel != zout) begin
                        tgt   <= sel;
                        cnt   <= tbl[det_idx];
                        state <= PEND;
                    end
                end
                PEND: begin
                    // Cancel wins over expiry when sel has already returned.
                    if (sel == zout) begin
                        state <= IDLE;
                        if (rej_cnt != 8'd255) begin
                            rej_cnt <= rej_cnt + 8'd1;
                        end
                    end else if (cnt == '0) begin
                        zout  <= tgt;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - DW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cond_path_delay_gen.sv
// Bench for cond_path_delay_gen: per-cycle vectors of {sel, mode, zout, busy}
// checked through an expected queue, plus direct checks of rej_cnt and wr_ready.
module tb_cond_path_delay_gen;

    localparam int DW = 4;
    localparam int DEF_DELAY = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          mode;
    logic          sel;
    logic          zout;
    logic          busy;
    logic          wr_valid;
    logic          wr_ready;
    logic          wr_cond;
    logic          wr_edge;
    logic [DW-1:0] wr_delay;
    logic [7:0]    rej_cnt;

    typedef struct packed {
        logic sel;
        logic mode;
        logic exp_z;
        logic exp_b;
    } vec_t;

    vec_t       vecs[$];
    logic [1:0] exp_q[$];
    int         n_cmp = 0;
    int         n_err = 0;

    cond_path_delay_gen #(.DW(DW), .DEF_DELAY(DEF_DELAY)) dut (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode),
        .sel      (sel),
        .zout     (zout),
        .busy     (busy),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_cond  (wr_cond),
        .wr_edge  (wr_edge),
        .wr_delay (wr_delay),
        .rej_cnt  (rej_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // One clock: inputs applied at the negedge, outputs checked at the next negedge.
    task automatic cyc(input logic s, input logic m, input logic ez, input logic eb);
        logic [1:0] e;
        sel  = s;
        mode = m;
        exp_q.push_back({ez, eb});
        @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        check("zout", int'(zout), int'(e[1]));
        check("busy", int'(busy), int'(e[0]));
    endtask

    task automatic push_n(input int n, input logic s, input logic m, input logic ez, input logic eb);
        vec_t v;
        v.sel = s; v.mode = m; v.exp_z = ez; v.exp_b = eb;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic run_vecs();
        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].sel, vecs[i].mode, vecs[i].exp_z, vecs[i].exp_b);
        end
        vecs.delete();
    endtask

    task automatic write_entry(input logic c, input logic e, input logic [DW-1:0] d);
        check("wr_ready_before_write", int'(wr_ready), 1);
        wr_valid = 1'b1;
        wr_cond  = c;
        wr_edge  = e;
        wr_delay = d;
        @(posedge clk);
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; sel = 1'b0; mode = 1'b0;
        wr_valid = 1'b0; wr_cond = 1'b0; wr_edge = 1'b0; wr_delay = '0;
        repeat (2) @(negedge clk);
        check("reset_zout", int'(zout), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_wr_ready", int'(wr_ready), 0);
        check("reset_rej_cnt", int'(rej_cnt), 0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("wr_ready_after_release", int'(wr_ready), 1);

        // Default delay 1, mode 0: rise lands two edges after detect.
        push_n(2, 1, 0, 0, 1);
        push_n(2, 1, 0, 1, 0);
        // Fall with default delay brings zout back to 0.
        push_n(2, 0, 0, 1, 1);
        push_n(1, 0, 0, 0, 0);
        run_vecs();
        check("rej_after_basic", int'(rej_cnt), 0);

        // mode=1 rise with delay 5; mode flips mid-pending and must not matter.
        write_entry(1'b1, 1'b0, 4'd5);
        write_entry(1'b0, 1'b0, 4'd2);
        push_n(2, 1, 1, 0, 1);
        push_n(4, 1, 0, 0, 1);
        push_n(1, 1, 0, 1, 0);
        push_n(2, 0, 0, 1, 1);
        push_n(1, 0, 0, 0, 0);
        run_vecs();

        // Rise delay 3: a 2-edge pulse is rejected, a 6-edge pulse gives 4 high cycles.
        write_entry(1'b0, 1'b0, 4'd3);
        push_n(2, 1, 0, 0, 1);
        push_n(2, 0, 0, 0, 0);
        run_vecs();
        check("rej_short_pulse", int'(rej_cnt), 1);
        push_n(4, 1, 0, 0, 1);
        push_n(2, 1, 0, 1, 0);
        push_n(2, 0, 0, 1, 1);
        push_n(2, 0, 0, 0, 0);
        run_vecs();
        check("rej_long_pulse", int'(rej_cnt), 1);

        // Zero delays: zout tracks sel one edge late, back-to-back detects.
        write_entry(1'b0, 1'b0, 4'd0);
        write_entry(1'b0, 1'b1, 4'd0);
        for (int i = 0; i < 10; i++) begin
            logic v;
            v = (i % 2 == 0);
            push_n(1, v, 0, ~v, 1);
            push_n(1, v, 0, v, 0);
        end
        run_vecs();
        check("rej_toggle", int'(rej_cnt), 1);

        // 300 one-edge pulses against delay 3: counter saturates.
        write_entry(1'b0, 1'b0, 4'd3);
        for (int i = 0; i < 300; i++) begin
            cyc(1, 0, 0, 1);
            cyc(0, 0, 0, 0);
            if (i == 252) check("rej_near_sat", int'(rej_cnt), 254);
        end
        check("rej_saturated", int'(rej_cnt), 255);

        // Write collision: entry rewritten on the detect edge, old value used.
        write_entry(1'b0, 1'b0, 4'd1);
        wr_valid = 1'b1; wr_cond = 1'b0; wr_edge = 1'b0; wr_delay = 4'd7;
        cyc(1, 0, 0, 1);
        wr_valid = 1'b0;
        cyc(1, 0, 0, 1);
        cyc(1, 0, 1, 0);
        cyc(0, 0, 1, 1);
        cyc(0, 0, 0, 0);
        push_n(8, 1, 0, 0, 1);
        push_n(1, 1, 0, 1, 0);
        run_vecs();

        // Reset while a fall is pending with cnt=4.
        write_entry(1'b0, 1'b1, 4'd7);
        push_n(4, 0, 0, 1, 1);
        run_vecs();
        rst = 1'b1;
        #1;
        check("midreset_zout", int'(zout), 0);
        check("midreset_busy", int'(busy), 0);
        check("midreset_wr_ready", int'(wr_ready), 0);
        check("midreset_rej_cnt", int'(rej_cnt), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("wr_ready_low_at_release", int'(wr_ready), 0);
        cyc(1, 0, 0, 1);
        check("wr_ready_one_edge_later", int'(wr_ready), 1);
        push_n(1, 1, 0, 0, 1);
        push_n(1, 1, 0, 1, 0);
        push_n(2, 0, 0, 1, 1);
        push_n(1, 0, 0, 0, 0);
        push_n(1, 1, 0, 0, 1);
        push_n(1, 1, 0, 0, 1);
        push_n(1, 1, 0, 1, 0);
        // Cancel on the expiry edge takes priority over the update.
        push_n(2, 0, 0, 1, 1);
        push_n(1, 1, 0, 1, 0);
        run_vecs();
        check("rej_expiry_cancel", int'(rej_cnt), 1);

        // Maximum delay 15 on the mode=1 rise entry: 16 cycles.
        cyc(0, 0, 1, 1);
        cyc(0, 0, 1, 1);
        cyc(0, 0, 0, 0);
        write_entry(1'b1, 1'b0, 4'd15);
        push_n(16, 1, 1, 0, 1);
        push_n(1, 1, 1, 1, 0);
        run_vecs();
        check("rej_final", int'(rej_cnt), 1);
        check("exp_q_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
